pipe_share_ctrl: RTL and testbench

Sequencing and arbitration controller that shares one 4-stage fixed-function 8-bit datapath (result = ((x+1)*2)-1 mod 2^8, latency 4 cycles, no stall, no valid) among NUM_REQ requesters. Round-robin grants one request per cycle into the datapath and tracks requester ID and valid alongside the data. Results are captured into a response FIFO, with credit-based issue so that no result is ever dropped. Sits between requester ports and the datapath instance in the parity/datapath subsystem.

---
 rtl/pipe_share_pkg.sv | 23 ++
 rtl/pipe_share_ctrl_if.sv | 30 +++
 rtl/pipe_resp_fifo.sv | 63 ++++++
 rtl/pipe_share_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_share_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_share_pkg.sv
// pipe_share_pkg
//   Shared constants and types for the shared-datapath controller.
//   DEF_DATA_W / DEF_PIPE_LAT : default operand width and datapath latency
//   MAX_ID_W                  : id field width, wide enough for 8 requesters
//   tag_t                     : {valid, id} travelling alongside the datapath
//   resp_entry_t              : {id, data} stored in the response FIFO
package pipe_share_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_PIPE_LAT = 4;
  localparam int MAX_ID_W     = 3;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

  typedef struct packed {
    logic [MAX_ID_W-1:0]   id;
    logic [DEF_DATA_W-1:0] data;
  } resp_entry_t;

endpackage

// File: rtl/pipe_share_ctrl_if.sv
// pipe_share_ctrl_if
//   Requester and response handshake bundle of pipe_share_ctrl.
//   req_valid/req_data/req_ready : per-requester issue handshake
//   resp_valid/resp_ready        : response handshake at the FIFO head
//   resp_data/resp_id            : head result and originating requester
//   master : requester/consumer side, slave : controller side
interface pipe_share_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [DATA_W-1:0]         resp_data;
  logic [ID_W-1:0]           resp_id;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/pipe_resp_fifo.sv
// pipe_resp_fifo
//   Synchronous show-ahead FIFO holding datapath results.
//   clk, reset_n   : clock, asynchronous active-low reset
//   push/push_entry: write one entry (ignored when full)
//   pop            : drop head entry (ignored when empty)
//   head_entry     : current head, all zero while empty
//   full/empty/count : occupancy status
module pipe_resp_fifo #(
  parameter int  DEPTH   = 8,
  parameter type entry_t = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  entry_t                   push_entry,
  input  logic                     pop,
  output entry_t                   head_entry,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     count_reg, count_next;
  logic            do_push, do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is masked while empty so the unreset storage never leaks out.
  assign head_entry = empty ? '0 : mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop)
      count_next = count_reg + 1'b1;
    else if (do_pop && !do_push)
      count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_reg] <= push_entry;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end
endmodule

// File: rtl/pipe_share_ctrl.sv
// pipe_share_ctrl
//   Shares one fixed-latency, stall-free datapath among NUM_REQ requesters.
//   Round-robin picks at most one request per cycle, a tag pipeline carries
//   {valid, id} alongside the datapath, and results land in a response FIFO.
//   Issue is credit-limited by inflight_cnt so the FIFO can never overflow.
//   clk, reset_n  : clock, asynchronous active-low reset
//   enable        : 1 allows new grants; in-flight work always drains
//   bus (slave)   : requester handshake and response FIFO head
//   pipe_data_in  : operand to the datapath (0 when nothing granted)
//   pipe_data_out : datapath result, PIPE_LAT cycles after issue
//   inflight_cnt  : operations issued but not yet popped
module pipe_share_ctrl
  import pipe_share_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int PIPE_LAT   = DEF_PIPE_LAT,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  pipe_share_ctrl_if.slave              bus,
  output logic [DATA_W-1:0]             pipe_data_in,
  input  logic [DATA_W-1:0]             pipe_data_out,
  output logic [$clog2(FIFO_DEPTH):0]   inflight_cnt
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int IDX_W = ID_W + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]  inflight_reg, inflight_next;
  tag_t [PIPE_LAT-1:0] tag_reg;

  logic              credit_ok, req_found, grant_valid;
  logic [ID_W-1:0]   grant_idx;
  logic [IDX_W-1:0]  rr_cand;
  logic [DATA_W-1:0] req_op [NUM_REQ];

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  resp_entry_t       fifo_in, fifo_head;

  // reset_n is folded in so req_ready reads 0 while reset is held.
  assign credit_ok   = reset_n && enable && (inflight_reg < CNT_W'(FIFO_DEPTH));
  assign grant_valid = req_found && credit_ok;

  // Scan from rr_ptr upwards with explicit wrap (NUM_REQ need not be 2^n).
  always_comb begin
    req_found = 1'b0;
    grant_idx = '0;
    rr_cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_cand = {1'b0, rr_ptr_reg} + IDX_W'(k);
      if (rr_cand >= IDX_W'(NUM_REQ))
        rr_cand = rr_cand - IDX_W'(NUM_REQ);
      if (!req_found && bus.req_valid[rr_cand[ID_W-1:0]]) begin
        req_found = 1'b1;
        grant_idx = rr_cand[ID_W-1:0];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_op[gi]        = bus.req_data[gi*DATA_W +: DATA_W];
      assign bus.req_ready[gi] = grant_valid && (grant_idx == ID_W'(gi));
    end
  endgenerate

  assign pipe_data_in = grant_valid ? req_op[grant_idx] : '0;

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_valid)
      rr_ptr_next = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
  end

  assign fifo_pop = !fifo_empty && bus.resp_ready;

  always_comb begin
    inflight_next = inflight_reg;
    if (grant_valid && !fifo_pop)
      inflight_next = inflight_reg + 1'b1;
    else if (fifo_pop && !grant_valid)
      inflight_next = inflight_reg - 1'b1;
  end

  // Tag stage k is valid in cycle T+1+k for a grant in cycle T, so the last
  // stage lines up with pipe_data_out in cycle T+PIPE_LAT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_reg   <= '0;
      inflight_reg <= '0;
      tag_reg      <= '0;
    end else begin
      rr_ptr_reg   <= rr_ptr_next;
      inflight_reg <= inflight_next;
      tag_reg[0]   <= '{valid: grant_valid, id: MAX_ID_W'(grant_idx)};
      for (int s = 1; s < PIPE_LAT; s++)
        tag_reg[s] <= tag_reg[s-1];
    end
  end

  assign fifo_push = tag_reg[PIPE_LAT-1].valid;
  assign fifo_in   = '{id: tag_reg[PIPE_LAT-1].id, data: DEF_DATA_W'(pipe_data_out)};

  pipe_resp_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (resp_entry_t)
  ) u_resp_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (fifo_push),
    .push_entry (fifo_in),
    .pop        (fifo_pop),
    .head_entry (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign bus.resp_valid = !fifo_empty;
  assign bus.resp_data  = DATA_W'(fifo_head.data);
  assign bus.resp_id    = ID_W'(fifo_head.id);
  assign inflight_cnt   = inflight_reg;

  // Credit accounting must keep every result a home in the FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(fifo_push && fifo_full));
  a_credit_covers_fifo: assert property (@(posedge clk) disable iff (!reset_n)
    inflight_reg >= fifo_count);
endmodule

// File: tb/tb_pipe_share_ctrl.sv
module tb_pipe_share_ctrl;
  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 8;
  localparam int PIPE_LAT   = 4;
  localparam int FIFO_DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] pipe_data_in;
  logic [7:0] pipe_data_out;
  logic [3:0] inflight_cnt;

  pipe_share_ctrl_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  pipe_share_ctrl #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .bus           (bus),
    .pipe_data_in  (pipe_data_in),
    .pipe_data_out (pipe_data_out),
    .inflight_cnt  (inflight_cnt)
  );

  // External 4-stage datapath: ((x+1)*2)-1, reset together with the controller.
  logic [7:0] s1, s2, s3, s4;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0; s2 <= '0; s3 <= '0; s4 <= '0;
    end else begin
      s1 <= pipe_data_in + 8'd1;
      s2 <= s1 + s1;
      s3 <= s2 - 8'd1;
      s4 <= s3;
    end
  end
  assign pipe_data_out = s4;

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_f(input logic [7:0] x);
    int v;
    v = ((int'(x) + 1) * 2 - 1) % 256;
    return 8'(v);
  endfunction

  typedef struct {
    logic [7:0] data;
    int         id;
    int         avail;
  } exp_t;

  exp_t sb[$];
  int   m_inflight = 0;
  int   m_rr = 0;
  bit   pop_seen = 1'b0;

  // Issue-side model: round-robin + credit rule, pushes expected responses.
  initial begin
    forever begin
      bit         g;
      int         gid;
      logic [3:0] exp_rdy;
      logic [7:0] op;
      @(negedge clk); #1;
      if (!reset_n) begin
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_pipe_data_in", pipe_data_in, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_data", bus.resp_data, 0);
        check("rst_resp_id", bus.resp_id, 0);
        check("rst_inflight", inflight_cnt, 0);
        sb.delete();
        m_inflight = 0;
        m_rr = 0;
        continue;
      end
      g = 1'b0; gid = 0; exp_rdy = '0; op = '0;
      if (enable && m_inflight < FIFO_DEPTH) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          int i;
          i = (m_rr + k) % NUM_REQ;
          if (!g && bus.req_valid[i]) begin
            g = 1'b1;
            gid = i;
          end
        end
      end
      if (g) begin
        exp_rdy[gid] = 1'b1;
        op = bus.req_data[gid*8 +: 8];
      end
      check("req_ready", bus.req_ready, exp_rdy);
      check("pipe_data_in", pipe_data_in, op);
      check("inflight_cnt", inflight_cnt, m_inflight);
      if (g) begin
        sb.push_back('{data: ref_f(op), id: gid, avail: cyc + PIPE_LAT + 1});
        m_rr = (gid + 1) % NUM_REQ;
      end
      m_inflight = m_inflight + (g ? 1 : 0) - (pop_seen ? 1 : 0);
    end
  end

  // Response monitor: compares the FIFO head against the scoreboard.
  initial begin
    forever begin
      bit exp_v;
      @(negedge clk);
      pop_seen = 1'b0;
      if (!reset_n) continue;
      exp_v = (sb.size() > 0) && (sb[0].avail <= cyc);
      check("resp_valid", bus.resp_valid, exp_v);
      if (bus.resp_valid && exp_v) begin
        check("resp_data", bus.resp_data, sb[0].data);
        check("resp_id", bus.resp_id, sb[0].id);
        if (bus.resp_ready) begin
          $display("resp id=%0d data=%02h cyc=%0d", bus.resp_id, bus.resp_data, cyc);
          void'(sb.pop_front());
          pop_seen = 1'b1;
        end
      end
    end
  end

  task automatic set_in(input logic en, input logic [3:0] v, input logic rr, input logic [31:0] d);
    @(posedge clk); #1;
    enable         = en;
    bus.req_valid  = v;
    bus.resp_ready = rr;
    bus.req_data   = d;
  endtask

  task automatic run(input int n, input logic en, input logic [3:0] v, input logic rr);
    for (int i = 0; i < n; i++) set_in(en, v, rr, $urandom());
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // single op from requester 0
    set_in(1'b1, 4'b0001, 1'b1, 32'h0000_0005);
    #2 check("single_grant", bus.req_ready, 4'b0001);
    run(8, 1'b1, 4'b0000, 1'b1);

    // wrap arithmetic from requester 2
    set_in(1'b1, 4'b0100, 1'b1, 32'h0080_0000);
    #2 check("wrap_grant", bus.req_ready, 4'b0100);
    set_in(1'b1, 4'b0100, 1'b1, 32'h00FF_0000);
    set_in(1'b1, 4'b0100, 1'b1, 32'h007F_0000);
    run(8, 1'b1, 4'b0000, 1'b1);

    // fairness with all requesters active
    run(20, 1'b1, 4'b1111, 1'b1);
    run(8, 1'b1, 4'b0000, 1'b1);

    // backpressure: credit caps issue at FIFO_DEPTH
    run(15, 1'b0 | 1'b1, 4'b1111, 1'b0);
    #2;
    check("bp_inflight", inflight_cnt, 8);
    check("bp_no_grant", bus.req_ready, 0);
    run(25, 1'b1, 4'b1111, 1'b1);
    run(10, 1'b1, 4'b0000, 1'b1);

    // enable drop after three issues
    run(3, 1'b1, 4'b1111, 1'b1);
    run(12, 1'b0, 4'b1111, 1'b1);

    // randomized traffic
    for (int i = 0; i < 300; i++)
      set_in($urandom_range(0, 9) != 0, 4'($urandom()), $urandom_range(0, 3) != 0, $urandom());
    run(12, 1'b0, 4'b0000, 1'b1);

    // reset with work in the pipeline and FIFO
    run(5, 1'b1, 4'b1111, 1'b0);
    run(1, 1'b0, 4'b0000, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    enable = 1'b0;
    bus.req_valid = '0;
    #2;
    check("midrst_resp_valid", bus.resp_valid, 0);
    check("midrst_inflight", inflight_cnt, 0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    set_in(1'b1, 4'b0010, 1'b1, 32'h0000_3300);
    #2 check("postrst_grant", bus.req_ready, 4'b0010);
    run(10, 1'b1, 4'b0000, 1'b1);

    // more random traffic, then drain
    for (int i = 0; i < 200; i++)
      set_in($urandom_range(0, 7) != 0, 4'($urandom()), $urandom_range(0, 2) != 0, $urandom());
    run(20, 1'b0, 4'b0000, 1'b1);
    @(negedge clk); #2;
    check("drain_empty", sb.size(), 0);
    check("drain_resp_valid", bus.resp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
